// File: rtl/crc3_frame_sched.sv
// crc3_frame_sched: round-robin scheduler sharing one serial CRC-3 encoder
// engine between NREQ requesters. Each frame clears the engine, shifts
// 5 message bits plus 3 zero pads, then collects the codeword (or times out).
// Optional feature macro: CRC3_CHECK_EN adds a shadow LFSR that flags
// codewords which disagree with the locally computed CRC.
module crc3_frame_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [5*NREQ-1:0]         req_msg,
  output logic [NREQ-1:0]           req_ready,
  output logic                      eng_clr,
  output logic                      eng_en,
  output logic                      eng_bit,
  input  logic [7:0]                eng_code,
  input  logic                      eng_done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_code,
  output logic [$clog2(NREQ)-1:0]   out_id,
  output logic                      out_timeout,
  output logic                      out_mismatch,
  output logic                      busy
);

  localparam int IDW               = $clog2(NREQ);
  localparam int unsigned NU       = NREQ;
  localparam logic [7:0]  W_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_WAIT,
    S_OUT
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [IDW-1:0]    last_grant;
  logic [4:0]        sr;
  logic [2:0]        k;
  logic [7:0]        w;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    gidx;
  logic              found;
  logic [31:0]       idx;
  logic [4:0]        msg_sel;

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= NU; off++) begin
      idx = (32'(last_grant) + off) % NU;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        grant[idx[IDW-1:0]] = 1'b1;
        gidx                = idx[IDW-1:0];
        found               = 1'b1;
      end
    end
  end

  assign msg_sel = req_msg[5*gidx +: 5];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic for the per-frame sequence.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (found) state_n = S_CLR;
      S_CLR:   state_n = S_SHIFT;
      S_SHIFT: if (k == 3'd7) state_n = S_WAIT;
      S_WAIT:  if (eng_done || (w == W_LAST)) state_n = S_OUT;
      S_OUT:   if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Moore/Mealy outputs: grants only in IDLE, engine strobes only in CLR/SHIFT.
  always_comb begin
    req_ready = '0;
    eng_clr   = 1'b0;
    eng_en    = 1'b0;
    eng_bit   = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:  req_ready = grant;
      S_CLR:   eng_clr   = 1'b1;
      S_SHIFT: begin
        eng_en  = 1'b1;
        eng_bit = sr[4];
      end
      S_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Frame datapath: message shifter (zero-filled for the pad bits), counters, result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant  <= IDW'(NREQ - 1);
      sr          <= '0;
      k           <= '0;
      w           <= '0;
      out_code    <= '0;
      out_id      <= '0;
      out_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (found) begin
          sr         <= msg_sel;
          out_id     <= gidx;
          last_grant <= gidx;
        end
        S_CLR:   k <= '0;
        S_SHIFT: begin
          sr <= {sr[3:0], 1'b0};
          k  <= k + 3'd1;
          w  <= '0;
        end
        S_WAIT: begin
          if (eng_done) begin
            out_code <= eng_code;
          end else if (w == W_LAST) begin
            out_code    <= '0;
            out_timeout <= 1'b1;
          end else begin
            w <= w + 8'd1;
          end
        end
        S_OUT:   if (out_ready) out_timeout <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CRC3_CHECK_EN
  logic [4:0] msg;
  logic [2:0] crc;

  // Shadow LFSR in lockstep with the engine; compares on capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg          <= '0;
      crc          <= '0;
      out_mismatch <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (found) msg <= msg_sel;
        S_CLR:   crc <= '0;
        S_SHIFT: crc <= {crc[1:0], eng_bit ^ crc[0] ^ crc[2]};
        S_WAIT:  if (eng_done) out_mismatch <= (eng_code != {msg, crc});
        S_OUT:   if (out_ready) out_mismatch <= 1'b0;
        default: ;
      endcase
    end
  end
`else
  assign out_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_crc3_frame_sched.sv
// Bench for crc3_frame_sched: behavioural engine model, table of arbitration
// frames, scoreboard queue of expected results, plus hand-written corner cases.
module tb_crc3_frame_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;
`ifdef CRC3_CHECK_EN
  localparam logic MM_EXP = 1'b1;
`else
  localparam logic MM_EXP = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_msg;
  logic [NREQ-1:0]   req_ready;
  logic              eng_clr, eng_en, eng_bit;
  logic [7:0]        eng_code;
  logic              eng_done;
  logic              out_valid, out_ready;
  logic [7:0]        out_code;
  logic [1:0]        out_id;
  logic              out_timeout, out_mismatch, busy;

  crc3_frame_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_msg(req_msg), .req_ready(req_ready),
    .eng_clr(eng_clr), .eng_en(eng_en), .eng_bit(eng_bit),
    .eng_code(eng_code), .eng_done(eng_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_id(out_id),
    .out_timeout(out_timeout), .out_mismatch(out_mismatch), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: serial LFSR x^3+x+1 as defined for the engine.
  logic       done_en;
  logic [7:0] corrupt;
  logic [2:0] m_crc = '0;
  logic [7:0] m_sh  = '0;
  logic [3:0] m_cnt = '0;

  always @(posedge clk) begin
    if (eng_clr) begin
      m_crc <= '0; m_sh <= '0; m_cnt <= '0;
    end else if (eng_en && m_cnt < 4'd8) begin
      m_sh  <= {m_sh[6:0], eng_bit};
      m_crc <= {m_crc[1:0], eng_bit ^ m_crc[0] ^ m_crc[2]};
      m_cnt <= m_cnt + 4'd1;
    end
  end
  assign eng_code = {m_sh[7:3], m_crc} ^ corrupt;
  assign eng_done = done_en && (m_cnt == 4'd8);

  // Strobe monitor.
  logic [7:0] cap_bits = '0;
  int         en_cnt   = 0;
  int         clr_cnt  = 0;
  always @(negedge clk) begin
    if (eng_en)  begin cap_bits <= {cap_bits[6:0], eng_bit}; en_cnt <= en_cnt + 1; end
    if (eng_clr) clr_cnt <= clr_cnt + 1;
  end

  typedef struct {
    logic [3:0]  v;
    logic [19:0] msgs;
    logic [1:0]  id;
    logic [7:0]  code;
  } vec_t;

  typedef struct {
    logic [7:0] code;
    logic [1:0] id;
    logic       to;
    logic       mm;
  } sb_t;

  sb_t  sb_q[$];
  vec_t tbl[9];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({req_ready, eng_clr, eng_en, eng_bit, out_valid, out_code,
                out_id, out_timeout, out_mismatch, busy});
  endfunction

  task automatic run_frame(input logic [3:0] v, input logic [19:0] msgs,
                           input logic [1:0] id, input logic [7:0] code,
                           input logic to, input logic mm, input int lat, input int hold);
    sb_t e;
    sb_t g;
    int  c;
    req_valid = v;
    req_msg   = msgs;
    out_ready = 1'b1;
    #1;
    chk("req_ready_onehot", 32'(req_ready), 32'(4'b0001 << id));
    e.code = code; e.id = id; e.to = to; e.mm = mm;
    sb_q.push_back(e);
    tick();
    req_valid = '0;
    c = 0;
    while (!out_valid && c < 60) begin
      tick();
      c++;
    end
    chk("latency", 32'(c), 32'(lat));
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        req_valid = 4'hF;
        #1;
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_code", 32'(out_code), 32'(code));
        chk("hold_ready", 32'(req_ready), 32'(0));
        tick();
      end
      req_valid = '0;
      out_ready = 1'b1;
    end
    chk("sb_depth", 32'(sb_q.size()), 32'(1));
    if (sb_q.size() > 0) begin
      g = sb_q.pop_front();
      chk("out_valid", 32'(out_valid), 32'(1));
      chk("out_code", 32'(out_code), 32'(g.code));
      chk("out_id", 32'(out_id), 32'(g.id));
      chk("out_timeout", 32'(out_timeout), 32'(g.to));
      chk("out_mismatch", 32'(out_mismatch), 32'(g.mm));
    end
    tick();
    chk("post_valid", 32'(out_valid), 32'(0));
    chk("post_busy", 32'(busy), 32'(0));
    chk("post_timeout", 32'(out_timeout), 32'(0));
    chk("post_mismatch", 32'(out_mismatch), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, e0;
    tbl[0] = '{4'b0101, {5'b00000, 5'b00001, 5'b00000, 5'b10110}, 2'd0, 8'hB6};
    tbl[1] = '{4'b0101, {5'b00000, 5'b00001, 5'b00000, 5'b10110}, 2'd2, 8'h0E};
    tbl[2] = '{4'b0101, {5'b00000, 5'b00001, 5'b00000, 5'b10110}, 2'd0, 8'hB6};
    tbl[3] = '{4'b1111, {5'b10000, 5'b01010, 5'b11111, 5'b10110}, 2'd1, 8'hFC};
    tbl[4] = '{4'b1111, {5'b10000, 5'b01010, 5'b11111, 5'b10110}, 2'd2, 8'h51};
    tbl[5] = '{4'b1111, {5'b10000, 5'b01010, 5'b11111, 5'b10110}, 2'd3, 8'h81};
    tbl[6] = '{4'b1001, {5'b10000, 5'b00000, 5'b00000, 5'b00111}, 2'd0, 8'h39};
    tbl[7] = '{4'b1000, {5'b11111, 5'b00000, 5'b00000, 5'b00000}, 2'd3, 8'hFC};
    tbl[8] = '{4'b0010, {5'b00000, 5'b00000, 5'b00111, 5'b00000}, 2'd1, 8'h39};

    rst_n = 1'b0; req_valid = '0; req_msg = '0; out_ready = 1'b1;
    done_en = 1'b1; corrupt = '0;
    tick(); tick(); tick();
    chk("reset_outputs", all_outs(), 32'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++)
      run_frame(tbl[i].v, tbl[i].msgs, tbl[i].id, tbl[i].code, 1'b0, 1'b0, 10, 0);

    // Bit stream for 5'b00001: one clear pulse, then 0,0,0,0,1,0,0,0.
    c0 = clr_cnt; e0 = en_cnt;
    run_frame(4'b0001, {15'b0, 5'b00001}, 2'd0, 8'h0E, 1'b0, 1'b0, 10, 0);
    chk("clr_pulses", 32'(clr_cnt - c0), 32'(1));
    chk("en_strobes", 32'(en_cnt - e0), 32'(8));
    chk("bit_stream", 32'(cap_bits), 32'(8'b00001000));

    // Engine never finishes: abort after TIMEOUT wait cycles.
    done_en = 1'b0;
    run_frame(4'b0001, {15'b0, 5'b10110}, 2'd0, 8'h00, 1'b1, 1'b0, 9 + TIMEOUT, 0);
    done_en = 1'b1;

    // Downstream back-pressure for 5 cycles.
    run_frame(4'b0100, {5'b0, 5'b11111, 10'b0}, 2'd2, 8'hFC, 1'b0, 1'b0, 10, 5);

    // Corrupted engine codeword.
    corrupt = 8'h01;
    run_frame(4'b0001, {15'b0, 5'b10110}, 2'd0, 8'hB7, 1'b0, MM_EXP, 10, 0);
    corrupt = '0;

    // Reset while shifting drops the frame.
    req_valid = 4'b0010; req_msg = {10'b0, 5'b10110, 5'b0};
    #1;
    tick();
    req_valid = '0;
    tick(); tick();
    chk("in_shift", 32'(eng_en), 32'(1));
    rst_n = 1'b0;
    tick();
    chk("reset_mid_frame", all_outs(), 32'(0));
    rst_n = 1'b1;
    tick();
    // last_grant back at NREQ-1, so req1 wins over req2.
    run_frame(4'b0110, {5'b0, 5'b10000, 5'b01010, 5'b0}, 2'd1, 8'h51, 1'b0, 1'b0, 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
